// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decode, ID/EX-EX/MEM-MEM/WB control regs, load-use stall.
// Optional jal/jalr/lui decode enabled by PIPE_CTRL_JUMP_EN.
module pipe_ctrl_unit #(
  parameter int ALUOP_W = 2,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode_id,
  input  logic [REG_W-1:0]   rs1_id,
  input  logic [REG_W-1:0]   rs2_id,
  input  logic [REG_W-1:0]   rd_id,
  input  logic               flush,
  input  logic               hold,
  output logic               stall,
  output logic               illegal_id,
  output logic               ex_alusrc,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [REG_W-1:0]   ex_rd,
  output logic               mem_memread,
  output logic               mem_memwrite,
  output logic               mem_branch,
  output logic               mem_jump,
  output logic [REG_W-1:0]   mem_rd,
  output logic               wb_regwrite,
  output logic               wb_memtoreg,
  output logic [REG_W-1:0]   wb_rd,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef struct packed {
    logic               alusrc;
    logic               memtoreg;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               branch;
    logic               jump;
    logic [ALUOP_W-1:0] aluop;
    logic [REG_W-1:0]   rd;
  } idex_t;

  typedef struct packed {
    logic             memtoreg;
    logic             regwrite;
    logic             memread;
    logic             memwrite;
    logic             branch;
    logic             jump;
    logic [REG_W-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic             memtoreg;
    logic             regwrite;
    logic [REG_W-1:0] rd;
  } memwb_t;

  idex_t      dec;
  idex_t      idex_q;
  exmem_t     exmem_q;
  memwb_t     memwb_q;
  logic       uses1;
  logic       uses2;
  logic       illegal;
  logic [CNT_W-1:0] cnt_q;

  logic op_r, op_lw, op_sw, op_beq, op_i, op_nop;
  assign op_r   = opcode_id == 7'b0110011;
  assign op_lw  = opcode_id == 7'b0000011;
  assign op_sw  = opcode_id == 7'b0100011;
  assign op_beq = opcode_id == 7'b1100011;
  assign op_i   = opcode_id == 7'b0010011;
  assign op_nop = opcode_id == 7'b0000000;
`ifdef PIPE_CTRL_JUMP_EN
  logic op_jal, op_jalr, op_lui;
  assign op_jal  = opcode_id == 7'b1101111;
  assign op_jalr = opcode_id == 7'b1100111;
  assign op_lui  = opcode_id == 7'b0110111;
`endif

  always_comb begin
    dec     = '0;
    uses1   = 1'b0;
    uses2   = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      op_r: begin
        dec.regwrite = 1'b1;
        dec.aluop    = ALUOP_W'(2'b10);
        uses1        = 1'b1;
        uses2        = 1'b1;
      end
      op_lw: begin
        dec.alusrc   = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        uses1        = 1'b1;
      end
      op_sw: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        uses1        = 1'b1;
        uses2        = 1'b1;
      end
      op_beq: begin
        dec.branch = 1'b1;
        dec.aluop  = ALUOP_W'(2'b01);
        uses1      = 1'b1;
        uses2      = 1'b1;
      end
      op_i: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = ALUOP_W'(2'b10);
        uses1        = 1'b1;
      end
`ifdef PIPE_CTRL_JUMP_EN
      op_jal: begin
        dec.regwrite = 1'b1;
        dec.jump     = 1'b1;
      end
      op_jalr: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.jump     = 1'b1;
        uses1        = 1'b1;
      end
      op_lui: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = ALUOP_W'(2'b11);
      end
`endif
      op_nop: ;
      default: illegal = 1'b1;
    endcase
    if (!illegal) dec.rd = rd_id;
  end

  // Only a load sitting in ID/EX can create a hazard the forwarding paths can't cover
  assign stall = idex_q.memread && (idex_q.rd != '0) &&
                 ((uses1 && rs1_id == idex_q.rd) ||
                  (uses2 && rs2_id == idex_q.rd)) &&
                 !flush && !hold;

  assign illegal_id = illegal && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      cnt_q   <= '0;
    end else if (!hold) begin
      memwb_q.memtoreg <= exmem_q.memtoreg;
      memwb_q.regwrite <= exmem_q.regwrite;
      memwb_q.rd       <= exmem_q.rd;
      if (flush) begin
        idex_q  <= '0;
        exmem_q <= '0;
      end else begin
        exmem_q.memtoreg <= idex_q.memtoreg;
        exmem_q.regwrite <= idex_q.regwrite;
        exmem_q.memread  <= idex_q.memread;
        exmem_q.memwrite <= idex_q.memwrite;
        exmem_q.branch   <= idex_q.branch;
        exmem_q.jump     <= idex_q.jump;
        exmem_q.rd       <= idex_q.rd;
        idex_q           <= stall ? '0 : dec;
      end
      if ((flush || stall) && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign ex_alusrc    = idex_q.alusrc;
  assign ex_aluop     = idex_q.aluop;
  assign ex_rd        = idex_q.rd;
  assign mem_memread  = exmem_q.memread;
  assign mem_memwrite = exmem_q.memwrite;
  assign mem_branch   = exmem_q.branch;
  assign mem_jump     = exmem_q.jump;
  assign mem_rd       = exmem_q.rd;
  assign wb_regwrite  = memwb_q.regwrite;
  assign wb_memtoreg  = memwb_q.memtoreg;
  assign wb_rd        = memwb_q.rd;
  assign bubble_cnt   = cnt_q;

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Successor to the combinational opcode decoder.
- Decodes the ID-stage opcode into the control bundle ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp.
- Carries the bundle, with rd, through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards, inserts bubbles, honours flush and global hold, and counts inserted bubbles.
- Sits between the IF/ID register and the datapath stage registers of the 5-stage core.

Parameters:
ALUOP_W, 2, ALUOp field width; must be >= 2; upper bits are zero-extended.
REG_W, 5, register-address width.
CNT_W, 16, width of the saturating bubble counter.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode_id  input  7  instruction[6:0] in ID
rs1_id  input  REG_W  instruction[19:15] in ID
rs2_id  input  REG_W  instruction[24:20] in ID
rd_id  input  REG_W  instruction[11:7] in ID
flush  input  1  branch taken (resolved in MEM); kills ID/EX and EX/MEM contents
hold  input  1  global freeze (memory wait)
stall  output  1  combinational; freezes PC and IF/ID
illegal_id  output  1  combinational; unknown opcode in ID
ex_alusrc  output  1  EX-stage control
ex_aluop  output  ALUOP_W  EX-stage control
ex_rd  output  REG_W  EX-stage control
mem_memread  output  1  MEM-stage control
mem_memwrite  output  1  MEM-stage control
mem_branch  output  1  MEM-stage control
mem_jump  output  1  MEM-stage control
mem_rd  output  REG_W  MEM-stage control
wb_regwrite  output  1  WB-stage control
wb_memtoreg  output  1  WB-stage control
wb_rd  output  REG_W  WB-stage control
bubble_cnt  output  CNT_W  saturating bubble count

Behaviour:
- Decode is combinational. Bundle order is {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp}:
  - 0110011 R-type: 001000_10
  - 0000011 lw: 111100_00
  - 0100011 sw: 100010_00
  - 1100011 beq: 000001_01
  - 0010011 I-ALU: 101000_10
  - 0000000: all zero, not illegal (canonical bubble)
  - any other opcode: all zero, illegal_id=1
- Jump is 0 for all the opcodes above.
- Register usage:
  - uses_rs1 = R, lw, sw, beq, I-ALU.
  - uses_rs2 = R, sw, beq.
- stall = ex_memread_q AND ex_rd!=0 AND ((uses_rs1 AND rs1_id==ex_rd) OR (uses_rs2 AND rs2_id==ex_rd)) AND NOT flush AND NOT hold.
  - ex_memread_q is the internal MemRead held in ID/EX.
- A bubble is all control bits 0 and rd=0.
- Per rising edge, first matching rule applies:
  1. reset: asynchronous; all stage registers become bubbles and bubble_cnt=0. All outputs are 0 while reset is high and after release.
  2. hold=1: all registers keep their value; bubble_cnt unchanged.
  3. flush=1: ID/EX and EX/MEM become bubbles; MEM/WB <= EX/MEM as normal.
  4. stall=1: ID/EX becomes a bubble; EX/MEM <= ID/EX; MEM/WB <= EX/MEM.
  5. otherwise: ID/EX <= decode (a bubble if illegal_id); EX/MEM <= ID/EX; MEM/WB <= EX/MEM.
- bubble_cnt increments by 1 on each edge where rule 3 or rule 4 is taken and rule 2 is not. It saturates at all-ones with no wrap.
- Latency: a decoded bundle appears on the ex_* outputs 1 cycle after ID, mem_* after 2 cycles, wb_* after 3 cycles.
- Each stall lasts exactly one cycle: after the bubble, ID/EX holds no load, so stall drops.
- Illegal opcodes never create register writes or memory side effects.

Optional Feature:
- Macro: PIPE_CTRL_JUMP_EN.
- When defined, extra decode entries:
  - 1101111 jal: RegWrite=1, Jump=1, ALUOp=00, uses no source registers.
  - 1100111 jalr: ALUSrc=1, RegWrite=1, Jump=1, ALUOp=00, uses_rs1.
  - 0110111 lui: ALUSrc=1, RegWrite=1, ALUOp=11, uses no source registers.
- Jump is carried through ID/EX into EX/MEM and appears on mem_jump; a flush also clears it.
- When undefined: mem_jump is tied to 0, and these three opcodes decode as illegal.
- The port list is identical in both builds.

Test Plan:
- Reset: assert reset mid-stream with a lw in ID/EX → all outputs 0 immediately and after release; bubble_cnt=0.
- Pipeline timing: R-type with rd=3, then opcode 0 → ex_aluop=10 and ex_rd=3 at +1; wb_regwrite=1 and wb_rd=3 at +3; never memread.
- Load-use: lw rd=5, then add with rs2=5 → stall=1 for exactly one cycle; ID/EX bubble; add reaches EX on the next cycle; bubble_cnt=1.
- No false hazard:
  - lw rd=0, then add with rs1=0 → no stall.
  - lw rd=5, then lui (JUMP_EN) → no stall.
- Flush and hold:
  - flush together with a pending load-use → stall=0, EX/MEM and ID/EX cleared, bubble_cnt +1.
  - hold for 3 cycles → outputs frozen, counter frozen.
- Illegal and saturation:
  - opcode 1111111 → illegal_id=1 and a bubble enters ID/EX.
  - CNT_W=2 with 5 stalls → bubble_cnt stays at 3.
  - jal with JUMP_EN → mem_jump=1 at +2; without the macro → illegal_id=1.
